// File: rtl/sifh_frame_sequencer.sv
// -----------------------------------------------------------------------------
// sifh_frame_sequencer
//   Frame-level controller for the serial SiFH histogram builder. One frame is
//   clear -> coarse pass (his_num=0) -> settle -> clear -> fine pass
//   (his_num=1) -> settle -> result hand-off. Timestamps accepted from the
//   TDC-side stream are forwarded to the builder as single-cycle write strobes
//   one cycle after acceptance.
//
// Ports
//   clk, res           clock, asynchronous active-low reset
//   start, abort       frame request (IDLE only) / synchronous frame abort
//   in_valid/in_data   upstream timestamp stream; in_ready = accept this cycle
//   wr_en/wr_data      registered write strobe and timestamp to the builder
//   his_num            0 = coarse pass, 1 = fine pass
//   his_clr_n          active-low histogram/RAM clear
//   data/pix/acq_idx   beat counters (data fastest, acquisition slowest)
//   busy               high in every state except IDLE
//   result_valid       fine-pass results stable, held until result_ack
//   frame_done         one-cycle pulse after the hand-off completes
// -----------------------------------------------------------------------------
module sifh_frame_sequencer #(
  parameter int NP         = 16,
  parameter int DATA_NUM   = 3,
  parameter int PIXEL_NUM  = 200,
  parameter int ACQ_NUM    = 33333,
  parameter int PD_LAT     = 4,
  parameter int CLR_CYCLES = 2,
  localparam int DW   = (DATA_NUM  > 1) ? $clog2(DATA_NUM)  : 1,
  localparam int PW   = (PIXEL_NUM > 1) ? $clog2(PIXEL_NUM) : 1,
  localparam int AW   = (ACQ_NUM   > 1) ? $clog2(ACQ_NUM)   : 1,
  localparam int MAXT = (PD_LAT > CLR_CYCLES) ? PD_LAT : CLR_CYCLES,
  localparam int TW   = $clog2(MAXT + 1)
) (
  input  logic          clk,
  input  logic          res,
  input  logic          start,
  input  logic          abort,
  input  logic          in_valid,
  input  logic [NP-1:0] in_data,
  output logic          in_ready,
  output logic          wr_en,
  output logic [NP-1:0] wr_data,
  output logic          his_num,
  output logic          his_clr_n,
  output logic [DW-1:0] data_idx,
  output logic [PW-1:0] pix_idx,
  output logic [AW-1:0] acq_idx,
  output logic          busy,
  output logic          result_valid,
  input  logic          result_ack,
  output logic          frame_done
);

  typedef enum logic [2:0] {
    IDLE, CLR0, COARSE, SET0, CLR1, FINE, SET1, OUTPUT
  } state_t;

  localparam logic [TW-1:0] CLR_LAST = TW'(CLR_CYCLES - 1);
  localparam logic [TW-1:0] PD_LAST  = TW'(PD_LAT - 1);

  state_t          r_state, w_nxt;
  logic [TW-1:0]   r_tmr;
  logic [DW-1:0]   r_d;
  logic [PW-1:0]   r_p;
  logic [AW-1:0]   r_a;
  logic            r_wr_en, r_his_num, r_abort_clr, r_done;
  logic [NP-1:0]   r_wr_data;
  logic            w_abort, w_acc, w_d_wrap, w_p_wrap, w_a_wrap, w_last;

  // abort only acts in busy states; in IDLE a start in the same cycle still wins
  assign w_abort  = abort & (r_state != IDLE);
  assign in_ready = (r_state == COARSE) | (r_state == FINE);
  assign w_acc    = in_valid & in_ready & ~w_abort;

  assign w_d_wrap = (r_d == DW'(DATA_NUM - 1));
  assign w_p_wrap = (r_p == PW'(PIXEL_NUM - 1));
  assign w_a_wrap = (r_a == AW'(ACQ_NUM - 1));
  assign w_last   = w_d_wrap & w_p_wrap & w_a_wrap;

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      IDLE:    if (start)               w_nxt = CLR0;
      CLR0:    if (r_tmr == CLR_LAST)   w_nxt = COARSE;
      COARSE:  if (w_acc && w_last)     w_nxt = SET0;
      SET0:    if (r_tmr == PD_LAST)    w_nxt = CLR1;
      CLR1:    if (r_tmr == CLR_LAST)   w_nxt = FINE;
      FINE:    if (w_acc && w_last)     w_nxt = SET1;
      SET1:    if (r_tmr == PD_LAST)    w_nxt = OUTPUT;
      OUTPUT:  if (result_ack)          w_nxt = IDLE;
      default:                          w_nxt = IDLE;
    endcase
    if (w_abort) w_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      r_state     <= IDLE;
      r_tmr       <= '0;
      r_d         <= '0;
      r_p         <= '0;
      r_a         <= '0;
      r_wr_en     <= 1'b0;
      r_wr_data   <= '0;
      r_his_num   <= 1'b0;
      r_abort_clr <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_nxt;
      // per-state dwell timer restarts on every state change
      r_tmr       <= (w_nxt != r_state) ? '0 : r_tmr + TW'(1);
      r_wr_en     <= w_acc;
      if (w_acc) r_wr_data <= in_data;
      r_abort_clr <= w_abort;
      r_done      <= (r_state == OUTPUT) & result_ack & ~w_abort;

      if (w_abort)
        r_his_num <= 1'b0;
      else if (r_state == SET0 && w_nxt == CLR1)
        r_his_num <= 1'b1;
      else if (r_state == OUTPUT && w_nxt == IDLE)
        r_his_num <= 1'b0;

      if (w_abort) begin
        r_d <= '0;
        r_p <= '0;
        r_a <= '0;
      end else if (w_acc) begin
        r_d <= w_d_wrap ? '0 : r_d + DW'(1);
        if (w_d_wrap) begin
          r_p <= w_p_wrap ? '0 : r_p + PW'(1);
          if (w_p_wrap) r_a <= w_a_wrap ? '0 : r_a + AW'(1);
        end
      end
    end
  end

  assign wr_en        = r_wr_en;
  assign wr_data      = r_wr_data;
  assign his_num      = r_his_num;
  // low while clearing, plus a single-cycle pulse after an abort
  assign his_clr_n    = ~((r_state == CLR0) | (r_state == CLR1) | r_abort_clr);
  assign data_idx     = r_d;
  assign pix_idx      = r_p;
  assign acq_idx      = r_a;
  assign busy         = (r_state != IDLE);
  assign result_valid = (r_state == OUTPUT);
  assign frame_done   = r_done;

endmodule

// File: tb/tb_sifh_frame_sequencer.sv
module tb_sifh_frame_sequencer;

  localparam int NP = 16, DN = 2, PN = 3, AN = 2, PDL = 2, CLC = 2;
  localparam int BEATS = DN * PN * AN;

  logic          clk = 1'b0, res = 1'b0;
  logic          start = 1'b0, abort = 1'b0, in_valid = 1'b0, result_ack = 1'b0;
  logic [NP-1:0] in_data = '0;
  logic          in_ready, wr_en, his_num, his_clr_n, busy, result_valid, frame_done;
  logic [NP-1:0] wr_data;
  logic [0:0]    data_idx;
  logic [1:0]    pix_idx;
  logic [0:0]    acq_idx;

  sifh_frame_sequencer #(
    .NP(NP), .DATA_NUM(DN), .PIXEL_NUM(PN), .ACQ_NUM(AN),
    .PD_LAT(PDL), .CLR_CYCLES(CLC)
  ) dut (
    .clk(clk), .res(res), .start(start), .abort(abort),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .wr_en(wr_en), .wr_data(wr_data), .his_num(his_num), .his_clr_n(his_clr_n),
    .data_idx(data_idx), .pix_idx(pix_idx), .acq_idx(acq_idx),
    .busy(busy), .result_valid(result_valid), .result_ack(result_ack),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct { logic [NP-1:0] d; logic hn; } exp_t;
  exp_t q[$];

  int nvec = 0, nfail = 0;
  int wr_cnt = 0, frame_wr0 = 0;
  int k = 0;   // accepted beats in the current pass

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // scoreboard monitor: every write strobe must match the next queued beat
  always @(negedge clk) begin
    if (res && wr_en) begin
      wr_cnt++;
      nvec++;
      if (q.size() == 0) begin
        nfail++;
        $display("FAIL unexpected_wr: got data %0h with empty queue at %0t", wr_data, $time);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (wr_data !== e.d || his_num !== e.hn) begin
          nfail++;
          $display("FAIL wr_beat: got data %0h his_num %0b expected data %0h his_num %0b at %0t",
                   wr_data, his_num, e.d, e.hn, $time);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idx(input string nm);
    chk({nm, "_data_idx"}, {31'd0, data_idx}, k % DN);
    chk({nm, "_pix_idx"},  {30'd0, pix_idx},  (k / DN) % PN);
    chk({nm, "_acq_idx"},  {31'd0, acq_idx},  (k / (DN * PN)) % AN);
  endtask

  task automatic beat(input logic [NP-1:0] v, input logic ph);
    exp_t e;
    in_valid = 1'b1;
    in_data  = v;
    e.d = v; e.hn = ph;
    q.push_back(e);
    tick();
    in_valid = 1'b0;
    k = (k + 1) % BEATS;
    chk_idx("beat");
  endtask

  task automatic pass(input int base, input logic ph, input bit tog, input bit inj);
    k = 0;
    for (int i = 0; i < BEATS; i++) begin
      if (tog) begin
        in_valid = 1'b0;
        in_data  = 16'hDEAD;
        tick();
        chk_idx("idle");
      end
      if (inj && i == 3) result_ack = 1'b1;
      beat(NP'(base + i), ph);
      result_ack = 1'b0;
    end
  endtask

  // start through entry into FINE, with explicit cycle-by-cycle checks
  task automatic front(input int base0, input bit tog, input bit inj);
    frame_wr0 = wr_cnt;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("clr0_a_clr_n", his_clr_n, 0);
    chk("clr0_busy", busy, 1);
    chk("clr0_his_num", his_num, 0);
    tick();
    chk("clr0_b_clr_n", his_clr_n, 0);
    chk("clr0_b_in_ready", in_ready, 0);
    tick();
    chk("coarse_clr_n", his_clr_n, 1);
    chk("coarse_in_ready", in_ready, 1);
    pass(base0, 1'b0, tog, inj);
    chk("set0_in_ready", in_ready, 0);
    chk("set0_busy", busy, 1);
    if (inj) start = 1'b1;
    tick();
    start = 1'b0;
    chk("set0_b_clr_n", his_clr_n, 1);
    chk("set0_b_his_num", his_num, 0);
    tick();
    chk("clr1_a_clr_n", his_clr_n, 0);
    chk("clr1_his_num", his_num, 1);
    tick();
    chk("clr1_b_clr_n", his_clr_n, 0);
    tick();
    chk("fine_clr_n", his_clr_n, 1);
    chk("fine_in_ready", in_ready, 1);
  endtask

  task automatic back(input int base1, input bit tog, input int hold);
    pass(base1, 1'b1, tog, 1'b0);
    chk("set1_a_rv", result_valid, 0);
    chk("set1_in_ready", in_ready, 0);
    tick();
    chk("set1_b_rv", result_valid, 0);
    tick();
    chk("out_rv", result_valid, 1);
    chk("out_his_num", his_num, 1);
    for (int i = 0; i < hold; i++) begin
      tick();
      chk("out_hold_rv", result_valid, 1);
      chk("out_hold_done", frame_done, 0);
    end
    result_ack = 1'b1;
    tick();
    result_ack = 1'b0;
    chk("done_pulse", frame_done, 1);
    chk("done_rv", result_valid, 0);
    chk("done_busy", busy, 0);
    chk("done_his_num", his_num, 0);
    tick();
    chk("done_end", frame_done, 0);
    chk("frame_wr_count", wr_cnt - frame_wr0, 2 * BEATS);
    chk("queue_empty", q.size(), 0);
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, "_wr_en"}, wr_en, 0);
    chk({nm, "_wr_data"}, wr_data, 0);
    chk({nm, "_his_num"}, his_num, 0);
    chk({nm, "_clr_n"}, his_clr_n, 1);
    chk({nm, "_idx"}, {data_idx, pix_idx, acq_idx}, 0);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_rv"}, result_valid, 0);
    chk({nm, "_done"}, frame_done, 0);
    chk({nm, "_in_ready"}, in_ready, 0);
  endtask

  initial begin
    #1;
    chk_reset_vals("por");
    tick();
    tick();
    res = 1'b1;
    tick();
    chk_reset_vals("idle");

    // reset in the middle of a coarse pass
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick();
    k = 0;
    for (int i = 0; i < 5; i++) beat(NP'(16'h50 + i), 1'b0);
    chk("mid_wr_en", wr_en, 1);
    res = 1'b0;
    q.delete();
    #1;
    chk_reset_vals("async_rst");
    tick();
    res = 1'b1;
    tick();

    // baseline: continuous stream, 10-cycle ack hold
    front(0, 1'b0, 1'b0);
    back(12, 1'b0, 10);

    // toggling in_valid
    front(100, 1'b1, 1'b0);
    back(200, 1'b1, 0);

    // start in SET0 and result_ack in COARSE are ignored
    front(16'h300, 1'b0, 1'b1);
    back(16'h400, 1'b0, 2);

    // abort on fine beat 4 with start in the same cycle
    front(16'h500, 1'b0, 1'b0);
    k = 0;
    for (int i = 0; i < 3; i++) beat(NP'(16'h600 + i), 1'b1);
    in_valid = 1'b1; in_data = 16'h6FF; abort = 1'b1; start = 1'b1;
    tick();
    in_valid = 1'b0; abort = 1'b0; start = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_clr_n", his_clr_n, 0);
    chk("abort_his_num", his_num, 0);
    chk("abort_idx", {data_idx, pix_idx, acq_idx}, 0);
    chk("abort_wr_en", wr_en, 0);
    chk("abort_done", frame_done, 0);
    chk("abort_rv", result_valid, 0);
    chk("abort_queue", q.size(), 0);

    // start on the very next cycle begins a full new frame
    front(16'h700, 1'b0, 1'b0);
    back(16'h800, 1'b0, 1);

    tick();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion before %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
